// File: rtl/bit_scan_iter.sv
// bit_scan_iter: enumerates the set-bit positions of an accepted word,
// lowest index first, one index per output handshake, with a last flag.
// Optional feature macro: BIT_SCAN_POPCNT_EN adds the out_popcnt port.
module bit_scan_iter #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDXW  = $clog2(WIDTH)
`ifdef BIT_SCAN_POPCNT_EN
  ,
  localparam int unsigned PCW   = $clog2(WIDTH + 1)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_pos,
  output logic             out_last,
  output logic             out_zero
`ifdef BIT_SCAN_POPCNT_EN
  ,
  output logic [PCW-1:0]   out_popcnt
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             zero_q, zero_d;
  logic [IDXW-1:0]  pos_c;
  logic             last_c;
  logic             in_hs_c;
  logic             out_hs_c;

`ifdef BIT_SCAN_POPCNT_EN
  logic [PCW-1:0]   popcnt_q, popcnt_d;

  function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n = n + PCW'(w[i]);
    end
    return n;
  endfunction

  assign out_popcnt = popcnt_q;
`endif

  // Priority encoder: index of the lowest remaining set bit (0 when empty).
  always_comb begin
    pos_c = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (work_q[i]) pos_c = IDXW'(i);
    end
  end

  // At most one bit left means the current beat is the final one.
  assign last_c = ((work_q & (work_q - WIDTH'(1))) == '0);

  assign out_valid = (state_q == S_EMIT);
  assign out_pos   = pos_c;
  assign out_last  = out_valid && last_c;
  assign out_zero  = zero_q;

  // A new word may enter while the final beat of the current one leaves.
  assign in_ready  = rst_n && ((state_q == S_IDLE) || (out_valid && out_ready && out_last));
  assign in_hs_c   = in_valid && in_ready;
  assign out_hs_c  = out_valid && out_ready;

  // Next-state: retire the lowest bit per output beat, load on input handshake.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    zero_d   = zero_q;
`ifdef BIT_SCAN_POPCNT_EN
    popcnt_d = popcnt_q;
`endif
    if (out_hs_c) begin
      work_d = work_q & (work_q - WIDTH'(1));
      if (out_last) begin
        state_d  = S_IDLE;
        zero_d   = 1'b0;
`ifdef BIT_SCAN_POPCNT_EN
        popcnt_d = '0;
`endif
      end
    end
    if (in_hs_c) begin
      state_d  = S_EMIT;
      work_d   = in_data;
      zero_d   = (in_data == '0);
`ifdef BIT_SCAN_POPCNT_EN
      popcnt_d = popcount(in_data);
`endif
    end
  end

  // State and work registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      zero_q   <= 1'b0;
`ifdef BIT_SCAN_POPCNT_EN
      popcnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      zero_q   <= zero_d;
`ifdef BIT_SCAN_POPCNT_EN
      popcnt_q <= popcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_scan_iter.sv
// Scoreboard bench for bit_scan_iter: directed cases plus random words.
module tb_bit_scan_iter;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_pos;
  logic          out_last;
  logic          out_zero;
`ifdef BIT_SCAN_POPCNT_EN
  logic [4:0]    out_popcnt;
`endif

  bit_scan_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_last  (out_last),
    .out_zero  (out_zero)
`ifdef BIT_SCAN_POPCNT_EN
    ,
    .out_popcnt(out_popcnt)
`endif
  );

  typedef struct {
    int pos;
    int last;
    int zero;
    int pc;
  } beat_t;

  beat_t sb[$];
  int    beat_cyc[$];
  int    nchecks = 0;
  int    errors  = 0;
  int    beat_cnt = 0;
  int    cyc = 0;
  int    mode = 0;  // 0: out_ready high, 1: random, 2: low

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: list of set positions ascending; empty word gives one zero beat.
  task automatic push_model(input logic [W-1:0] w);
    int    idx[$];
    beat_t b;
    for (int i = 0; i < int'(W); i++) if (w[i]) idx.push_back(i);
    if (idx.size() == 0) begin
      b.pos = 0; b.last = 1; b.zero = 1; b.pc = 0;
      sb.push_back(b);
    end else begin
      for (int k = 0; k < idx.size(); k++) begin
        b.pos  = idx[k];
        b.last = (k == idx.size() - 1) ? 1 : 0;
        b.zero = 0;
        b.pc   = idx.size();
        sb.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    case (mode)
      0:       out_ready = 1'b1;
      2:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Present a word from a negedge until accepted; returns at a negedge.
  task automatic send(input logic [W-1:0] w);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 300; t++) begin
      #4;
      if (in_ready) begin
        push_model(w);
        acc = 1;
      end
      tick();
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 500; t++) begin
      #4;
      if (sb.size() == 0 && !out_valid) ok = 1;
      tick();
      if (ok) break;
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  // Monitor: pops expected beats on each output handshake and checks stalls.
  initial begin
    bit    prev_stall = 0;
    int    p_pos = 0, p_last = 0, p_zero = 0, p_pc = 0;
    beat_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_pos", int'(out_pos), p_pos);
          check("stall_last", int'(out_last), p_last);
          check("stall_zero", int'(out_zero), p_zero);
`ifdef BIT_SCAN_POPCNT_EN
          check("stall_popcnt", int'(out_popcnt), p_pc);
`endif
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            nchecks++;
            errors++;
            $display("FAIL unexpected_beat: got pos %0d with no expected beat (t=%0t)", out_pos, $time);
          end else begin
            e = sb.pop_front();
            check("beat_pos", int'(out_pos), e.pos);
            check("beat_last", int'(out_last), e.last);
            check("beat_zero", int'(out_zero), e.zero);
`ifdef BIT_SCAN_POPCNT_EN
            check("beat_popcnt", int'(out_popcnt), e.pc);
`endif
          end
          beat_cnt++;
          beat_cyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        p_pos  = int'(out_pos);
        p_last = int'(out_last);
        p_zero = int'(out_zero);
`ifdef BIT_SCAN_POPCNT_EN
        p_pc   = int'(out_popcnt);
`endif
      end
    end
  end

  initial begin
    int          b0;
    int          n;
    logic [W-1:0] w;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    out_ready = 1'b1;

    // Reset values with in_valid asserted.
    repeat (3) @(negedge clk);
    #4;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pos", int'(out_pos), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_zero", int'(out_zero), 0);
`ifdef BIT_SCAN_POPCNT_EN
    check("rst_out_popcnt", int'(out_popcnt), 0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #4;
    check("post_rst_in_ready", int'(in_ready), 1);
    tick();

    // Sparse word, out_ready high.
    mode = 0;
    b0 = beat_cnt;
    send(16'h8421);
    wait_idle();
    check("beats_8421", beat_cnt - b0, 4);

    // All-zero word.
    b0 = beat_cnt;
    send(16'h0000);
    wait_idle();
    check("beats_zero", beat_cnt - b0, 1);

    // Stall on first beat of 0x0006.
    mode = 2;
    out_ready = 1'b0;
    b0 = beat_cnt;
    send(16'h0006);
    for (int s = 0; s < 3; s++) begin
      #4;
      check("stall_dir_valid", int'(out_valid), 1);
      check("stall_dir_pos", int'(out_pos), 1);
      check("stall_dir_last", int'(out_last), 0);
      check("stall_dir_in_ready", int'(in_ready), 0);
      tick();
    end
    mode = 0;
    out_ready = 1'b1;
    wait_idle();
    check("beats_0006", beat_cnt - b0, 2);

    // Back-to-back words with no bubble.
    beat_cyc.delete();
    send(16'h0010);
    send(16'h0003);
    wait_idle();
    n = beat_cyc.size();
    check("b2b_beats", n, 3);
    if (n == 3) begin
      check("b2b_gap1", beat_cyc[1] - beat_cyc[0], 1);
      check("b2b_gap2", beat_cyc[2] - beat_cyc[1], 1);
    end

    // Reset in the middle of 0xFFFF after three beats.
    b0 = beat_cnt;
    send(16'hFFFF);
    for (int t = 0; t < 50; t++) begin
      if (beat_cnt - b0 >= 3) break;
      tick();
    end
    check("mid_rst_beats", beat_cnt - b0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_out_last", int'(out_last), 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #4;
      check("post_mid_rst_valid", int'(out_valid), 0);
      check("post_mid_rst_in_ready", int'(in_ready), 1);
      tick();
    end

    // Random words with random backpressure and idle gaps.
    mode = 1;
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 5))
        0:       w = '0;
        1:       w = '1;
        2:       w = W'($urandom) & W'($urandom) & W'($urandom);
        default: w = W'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) tick();
      send(w);
    end
    mode = 0;
    wait_idle();
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
